ofmap_writeback_controller: RTL and testbench

Runtime-configurable output-feature-map write controller. It sits between the MAC array output stage and the OFMap SRAM. It generates one SRAM write address per accepted output word, walking width, then height, then channel group. Compared with the fixed-geometry controller it replaces, it adds:
- dimensions and base address latched at run start,
- selectable memory layout,
- memory-side backpressure,
- an explicit start/busy/done handshake with configuration error detection.

---
 rtl/ofmap_writeback_controller.sv | 175 +++++++++++++++++
 tb/tb_ofmap_writeback_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ofmap_writeback_controller.sv
// Purpose : OFMap SRAM write-address generator with runtime geometry and layout, start/busy/done handshake.
// Latency : zero-cycle fire-to-strobe; address is combinational from latched config and registered counters.
// Backpr. : a word is consumed only when ofmap_valid_in & mem_ready_in in RUN; counters hold otherwise.
//
// Ports:
//   clk, rstn                     clock, asynchronous active-low reset
//   start_in, cfg_*_in            run start pulse and geometry/base/layout, sampled on the start cycle
//   ofmap_valid_in, mem_ready_in  array-side valid, SRAM-side ready
//   ofmap_accept_out              word consumed this cycle (same as ofmap_write_en_out)
//   ofmap_addr_out                SRAM write address
//   ofmap_write_en_out            SRAM write strobe
//   ofmap_write_done_out          one-cycle pulse after the last write of a run
//   busy_out                      high while a run is active or finishing
//   cfg_error_out                 one-cycle pulse after a start with zero W, H or G
module ofmap_writeback_controller #(
  parameter int MAC_COL        = 16,
  parameter int OFMAP_ADDR_BIT = 10,
  parameter int DIM_BIT        = 8,
  parameter int CHG_BIT        = 4
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start_in,
  input  logic [DIM_BIT-1:0]        cfg_width_in,
  input  logic [DIM_BIT-1:0]        cfg_height_in,
  input  logic [CHG_BIT-1:0]        cfg_ch_groups_in,
  input  logic [OFMAP_ADDR_BIT-1:0] cfg_base_addr_in,
  input  logic                      cfg_layout_in,
  input  logic                      ofmap_valid_in,
  input  logic                      mem_ready_in,
  output logic                      ofmap_accept_out,
  output logic [OFMAP_ADDR_BIT-1:0] ofmap_addr_out,
  output logic                      ofmap_write_en_out,
  output logic                      ofmap_write_done_out,
  output logic                      busy_out,
  output logic                      cfg_error_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Wide enough for the full-precision index G*H*W plus the base address.
  localparam int PW = 2 * DIM_BIT + CHG_BIT + OFMAP_ADDR_BIT;

  localparam logic [DIM_BIT-1:0] DIM_ONE = 1;
  localparam logic [CHG_BIT-1:0] CHG_ONE = 1;

  logic [1:0]                state_q, state_d;
  logic [DIM_BIT-1:0]        w_q, w_d, h_q, h_d;
  logic [CHG_BIT-1:0]        g_q, g_d;
  logic [DIM_BIT-1:0]        cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d;
  logic [CHG_BIT-1:0]        cfg_g_q, cfg_g_d;
  logic [OFMAP_ADDR_BIT-1:0] cfg_base_q, cfg_base_d;
  logic                      cfg_layout_q, cfg_layout_d;
  logic                      cfg_err_q, cfg_err_d;

  logic fire;
  logic cfg_zero;
  logic w_last, h_last, g_last;

  assign fire     = (state_q == S_RUN) & ofmap_valid_in & mem_ready_in;
  assign cfg_zero = (cfg_width_in == '0) | (cfg_height_in == '0) | (cfg_ch_groups_in == '0);
  assign w_last   = (w_q == cfg_w_q - DIM_ONE);
  assign h_last   = (h_q == cfg_h_q - DIM_ONE);
  assign g_last   = (g_q == cfg_g_q - CHG_ONE);

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    g_d          = g_q;
    cfg_w_d      = cfg_w_q;
    cfg_h_d      = cfg_h_q;
    cfg_g_d      = cfg_g_q;
    cfg_base_d   = cfg_base_q;
    cfg_layout_d = cfg_layout_q;
    cfg_err_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          if (cfg_zero) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d      = S_RUN;
            cfg_w_d      = cfg_width_in;
            cfg_h_d      = cfg_height_in;
            cfg_g_d      = cfg_ch_groups_in;
            cfg_base_d   = cfg_base_addr_in;
            cfg_layout_d = cfg_layout_in;
            w_d          = '0;
            h_d          = '0;
            g_d          = '0;
          end
        end
      end
      S_RUN: begin
        if (fire) begin
          // Width is the fastest-moving coordinate, then height, then channel group.
          if (w_last) begin
            w_d = '0;
            if (h_last) begin
              h_d = '0;
              if (g_last) begin
                g_d     = '0;
                state_d = S_DONE;
              end else begin
                g_d = g_q + CHG_ONE;
              end
            end else begin
              h_d = h_q + DIM_ONE;
            end
          end else begin
            w_d = w_q + DIM_ONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      w_q          <= '0;
      h_q          <= '0;
      g_q          <= '0;
      cfg_w_q      <= '0;
      cfg_h_q      <= '0;
      cfg_g_q      <= '0;
      cfg_base_q   <= '0;
      cfg_layout_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_q          <= w_d;
      h_q          <= h_d;
      g_q          <= g_d;
      cfg_w_q      <= cfg_w_d;
      cfg_h_q      <= cfg_h_d;
      cfg_g_q      <= cfg_g_d;
      cfg_base_q   <= cfg_base_d;
      cfg_layout_q <= cfg_layout_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // Address: full-precision products, summed, then truncated so it wraps modulo 2^OFMAP_ADDR_BIT.
  logic [PW-1:0] w_x, h_x, g_x, cw_x, ch_x, cg_x, base_x, idx_x;

  assign w_x    = PW'(w_q);
  assign h_x    = PW'(h_q);
  assign g_x    = PW'(g_q);
  assign cw_x   = PW'(cfg_w_q);
  assign ch_x   = PW'(cfg_h_q);
  assign cg_x   = PW'(cfg_g_q);
  assign base_x = PW'(cfg_base_q);

  always_comb begin
    if (cfg_layout_q) begin
      idx_x = g_x * ch_x * cw_x + h_x * cw_x + w_x;   // planar: G slowest
    end else begin
      idx_x = (h_x * cw_x + w_x) * cg_x + g_x;        // interleaved: G fastest
    end
  end

  assign ofmap_addr_out       = OFMAP_ADDR_BIT'(base_x + idx_x);
  assign ofmap_write_en_out   = fire;
  assign ofmap_accept_out     = fire;
  assign ofmap_write_done_out = (state_q == S_DONE);
  assign busy_out             = (state_q == S_RUN) | (state_q == S_DONE);
  assign cfg_error_out        = cfg_err_q;

endmodule

// File: tb/tb_ofmap_writeback_controller.sv
// Purpose : self-checking bench for ofmap_writeback_controller (scoreboard of expected addresses).
// Latency : checks zero-latency strobe, done one cycle after the last write, busy drop one cycle later.
// Backpr. : drives random mem_ready_in and a valid bubble; strobe must follow valid & ready exactly.
module tb_ofmap_writeback_controller;

  localparam int AB = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start_in;
  logic [7:0]    cfg_width_in, cfg_height_in;
  logic [3:0]    cfg_ch_groups_in;
  logic [AB-1:0] cfg_base_addr_in;
  logic          cfg_layout_in;
  logic          ofmap_valid_in, mem_ready_in;
  logic          ofmap_accept_out;
  logic [AB-1:0] ofmap_addr_out;
  logic          ofmap_write_en_out, ofmap_write_done_out, busy_out, cfg_error_out;

  ofmap_writeback_controller #(
    .MAC_COL(16), .OFMAP_ADDR_BIT(AB), .DIM_BIT(8), .CHG_BIT(4)
  ) dut (
    .clk(clk), .rstn(rstn), .start_in(start_in),
    .cfg_width_in(cfg_width_in), .cfg_height_in(cfg_height_in),
    .cfg_ch_groups_in(cfg_ch_groups_in), .cfg_base_addr_in(cfg_base_addr_in),
    .cfg_layout_in(cfg_layout_in), .ofmap_valid_in(ofmap_valid_in),
    .mem_ready_in(mem_ready_in), .ofmap_accept_out(ofmap_accept_out),
    .ofmap_addr_out(ofmap_addr_out), .ofmap_write_en_out(ofmap_write_en_out),
    .ofmap_write_done_out(ofmap_write_done_out), .busy_out(busy_out),
    .cfg_error_out(cfg_error_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected address sequence in write order (w fastest, then h, then g).
  task automatic push_expected(input int w, input int h, input int g, input int base, input int lay);
    int n = 0;
    for (int gi = 0; gi < g; gi++)
      for (int hi = 0; hi < h; hi++)
        for (int wi = 0; wi < w; wi++) begin
          if (lay == 1) exp_q.push_back((base + n) % 1024);
          else          exp_q.push_back((base + (hi * w + wi) * g + gi) % 1024);
          n++;
        end
  endtask

  task automatic drive_start(input int w, input int h, input int g, input int base, input int lay);
    start_in         = 1'b1;
    cfg_width_in     = 8'(w);
    cfg_height_in    = 8'(h);
    cfg_ch_groups_in = 4'(g);
    cfg_base_addr_in = AB'(base);
    cfg_layout_in    = 1'(lay);
  endtask

  // One full run; returns the first and last observed write addresses.
  task automatic do_run(input int w, input int h, input int g, input int base, input int lay,
                        input int stall, input int inject, output int first_a, output int last_a);
    int total, n, cyc;
    total   = w * h * g;
    first_a = -1;
    last_a  = -1;
    push_expected(w, h, g, base, lay);
    @(negedge clk);
    drive_start(w, h, g, base, lay);
    ofmap_valid_in = 1'b0;
    mem_ready_in   = 1'b0;
    @(negedge clk);
    start_in = 1'b0;
    #1 chk("busy_after_start", busy_out, 1);
    n   = 0;
    cyc = 0;
    while (n < total && cyc < 5000) begin
      if (stall != 0) begin
        ofmap_valid_in = (cyc >= 3 && cyc < 8) ? 1'b0 : 1'b1;
        mem_ready_in   = 1'($urandom_range(0, 1));
      end else begin
        ofmap_valid_in = 1'b1;
        mem_ready_in   = 1'b1;
      end
      // A start during RUN with a different geometry must be ignored.
      if (inject != 0 && cyc == 4) drive_start(1, 1, 1, 7, 0);
      else                         start_in = 1'b0;
      #1;
      chk("strobe_vs_handshake", ofmap_write_en_out, int'(ofmap_valid_in & mem_ready_in));
      chk("accept_eq_strobe", ofmap_accept_out, ofmap_write_en_out);
      if (ofmap_write_done_out) chk("early_done", 1, 0);
      if (ofmap_write_en_out) begin
        if (exp_q.size() == 0) chk("extra_write", 1, 0);
        else                   chk("write_addr", ofmap_addr_out, exp_q.pop_front());
        if (first_a < 0) first_a = ofmap_addr_out;
        last_a = ofmap_addr_out;
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    start_in = 1'b0;
    chk("run_write_count", n, total);
    // DONE cycle: valid/ready held high, still no strobe allowed.
    ofmap_valid_in = 1'b1;
    mem_ready_in   = 1'b1;
    #1;
    chk("done_pulse", ofmap_write_done_out, 1);
    chk("busy_in_done", busy_out, 1);
    chk("no_write_in_done", ofmap_write_en_out, 0);
    @(negedge clk);
    #1;
    chk("done_single", ofmap_write_done_out, 0);
    chk("busy_dropped", busy_out, 0);
    chk("no_write_in_idle", ofmap_write_en_out, 0);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    ofmap_valid_in = 1'b0;
    mem_ready_in   = 1'b0;
  endtask

  typedef struct {
    int w, h, g, base, lay, stall, inject;
    int exp_first, exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fa, la, wr;
    vecs[0] = '{14, 14, 4, 0,    0, 0, 0, 0,   783};
    vecs[1] = '{3,  2,  2, 100,  1, 0, 0, 100, 111};
    vecs[2] = '{3,  2,  2, 100,  0, 0, 0, 100, 111};
    vecs[3] = '{3,  2,  2, 100,  0, 1, 0, 100, 111};
    vecs[4] = '{3,  2,  2, 100,  1, 0, 1, 100, 111};
    vecs[5] = '{255, 8, 1, 1000, 0, 0, 0, 1000, 991};

    rstn = 1'b0;
    start_in = 1'b0;
    drive_start(0, 0, 0, 0, 0);
    start_in = 1'b0;
    ofmap_valid_in = 1'b1;
    mem_ready_in   = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_write_en", ofmap_write_en_out, 0);
    chk("rst_accept", ofmap_accept_out, 0);
    chk("rst_done", ofmap_write_done_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_cfg_error", cfg_error_out, 0);
    chk("rst_addr", ofmap_addr_out, 0);
    @(negedge clk);
    rstn = 1'b1;
    ofmap_valid_in = 1'b0;
    mem_ready_in   = 1'b0;

    foreach (vecs[i]) begin
      do_run(vecs[i].w, vecs[i].h, vecs[i].g, vecs[i].base, vecs[i].lay,
             vecs[i].stall, vecs[i].inject, fa, la);
      chk($sformatf("vec%0d_first_addr", i), fa, vecs[i].exp_first);
      chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_last);
    end

    // Rejected start: zero height.
    @(negedge clk);
    drive_start(4, 0, 2, 3, 0);
    ofmap_valid_in = 1'b1;
    mem_ready_in   = 1'b1;
    @(negedge clk);
    start_in = 1'b0;
    #1;
    chk("cfg_error_pulse", cfg_error_out, 1);
    chk("cfg_error_busy", busy_out, 0);
    chk("cfg_error_no_write", ofmap_write_en_out, 0);
    @(negedge clk);
    #1;
    chk("cfg_error_single", cfg_error_out, 0);
    chk("cfg_error_still_idle", busy_out, 0);
    chk("cfg_error_no_write2", ofmap_write_en_out, 0);

    // Reset in the middle of a 4x4x4 run, after write 37.
    @(negedge clk);
    drive_start(4, 4, 4, 5, 0);
    ofmap_valid_in = 1'b0;
    @(negedge clk);
    start_in = 1'b0;
    ofmap_valid_in = 1'b1;
    wr = 0;
    for (int c = 0; c < 200 && wr < 37; c++) begin
      #1;
      if (ofmap_write_en_out) wr++;
      @(negedge clk);
    end
    chk("midrun_writes", wr, 37);
    rstn = 1'b0;
    #1;
    chk("midrun_rst_write_en", ofmap_write_en_out, 0);
    chk("midrun_rst_accept", ofmap_accept_out, 0);
    chk("midrun_rst_done", ofmap_write_done_out, 0);
    chk("midrun_rst_busy", busy_out, 0);
    chk("midrun_rst_addr", ofmap_addr_out, 0);
    @(negedge clk);
    #1 chk("midrun_rst_no_done", ofmap_write_done_out, 0);
    rstn = 1'b1;
    ofmap_valid_in = 1'b0;
    mem_ready_in   = 1'b0;
    do_run(4, 4, 4, 5, 0, 0, 0, fa, la);
    chk("post_rst_first_addr", fa, 5);
    chk("post_rst_last_addr", la, 68);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
